decode_execute_stage: RTL and testbench
=======================================

# decode_execute_stage

Pipeline boundary between the decode stage (opcode decoder, register files) and the execute stage (scalar ALU, vector ALU, memory). It registers the decoded 20-bit control word, operand data and register addresses into the EX stage. It detects load-use hazards against the instruction currently in EX and stalls decode, inserting nop bubbles for 1 cycle after a scalar load and a parameterised number of cycles after a vector load. It also squashes the EX slot when a branch taken is signalled.

## Interface
Parameters:
- DATA_W, 16: scalar operand width.
- VDATA_W, 128: vector operand width.
- REG_ADDR_W, 4: scalar register address width.
- VREG_ADDR_W, 3: vector register address width.
- VLOAD_STALL, 2: bubbles after vldr (legal range 1..7).

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_d  in  1  decode holds a real instruction.
- control_signals_d  in  20  decoder word: [18] load, [17] wre, [16] vector_wre, [15] wme_a, [14] wme_b, [13:12] wb mux, [11:10] vector wb mux, [9:5] aluOp, [4:0] aluVectorOp.
- rd_d, rs1_d, rs2_d  in  REG_ADDR_W  scalar destination and sources.
- use_rs1_d, use_rs2_d  in  1  source actually read.
- vrd_d, vrs1_d, vrs2_d  in  VREG_ADDR_W  vector destination and sources.
- use_vrs1_d, use_vrs2_d  in  1  vector source actually read.
- rs1_data_d, rs2_data_d  in  DATA_W  scalar operands.
- vrs1_data_d, vrs2_data_d  in  VDATA_W  vector operands.
- flush_e  in  1  branch taken resolved in EX.
- stall_d  out  1  hold PC and decode (combinational).
- valid_e  out  1  EX slot holds a real instruction.
- control_signals_e  out  20  registered control word.
- rd_e, vrd_e, rs1_data_e, rs2_data_e, vrs1_data_e, vrs2_data_e  out  matching widths  registered copies.

## Operation
- Scalar hazard, H_s: valid_e & ctrl_e[18] & ctrl_e[17] & valid_d & ((use_rs1_d & rs1_d==rd_e) | (use_rs2_d & rs2_d==rd_e)).
- Vector hazard, H_v: valid_e & ctrl_e[16] & ctrl_e[4:0]==5'b10010 & valid_d & matching vrs1/vrs2 against vrd_e. Vector ALU ops writing vrd do not stall; forwarding handles them.
- FSM states are RUN and STALL, with a 3-bit counter cnt.
- RUN, no hazard: load the D inputs into EX; stall_d=0.
- RUN with H_s: stall_d=1; EX loads a bubble; stay in RUN.
- RUN with H_v: stall_d=1; EX loads a bubble. If VLOAD_STALL>1, go to STALL with cnt=VLOAD_STALL-1.
- STALL: stall_d=1; EX loads a bubble; decrement cnt. Return to RUN when cnt==1.
- Bubble: valid_e=0 and control_signals_e=0, which is a nop. Address and data registers hold their previous values.
- flush_e has priority over everything. EX loads a bubble, state goes to RUN, cnt=0 and stall_d=0 in the same cycle, so fetch redirects.
- valid_d=0 with no hazard: EX loads a bubble.

## Timing
- Latency: one cycle from D inputs to _e outputs.
- stall_d is combinational from the EX registers and D inputs. It has no path from flush_e other than forcing stall_d to 0.
- Scalar load-use costs exactly 1 bubble. Vector load-use costs exactly VLOAD_STALL bubbles.
- Decode must present the same instruction, unchanged, for every cycle that stall_d=1.
- Reset (asynchronous, at any time, including mid-STALL):
  - all _e outputs = 0;
  - state = RUN, cnt = 0;
  - stall_d = 0 while rst is high.
- Back-to-back loads: a hazard on the second load restarts detection against whatever sits in EX. No cumulative counting.

## Structure
- Shared package cpu_pkg holds:
  - control-word bit-index constants (CTRL_LOAD=18, CTRL_WRE=17, CTRL_VWRE=16, …);
  - opcode constants (OP_LDR=5'b00010, OP_VLDR=5'b10010, …);
  - the state_t enum {RUN, STALL}.
- One natural sub-module, hazard_detect: purely combinational, computes H_s and H_v. The FSM, counter and EX registers stay in decode_execute_stage.

## Test plan
- Reset: assert rst mid-STALL with VLOAD_STALL=2 -> all _e outputs 0 and stall_d 0 immediately; next instruction passes after rst falls.
- ldr r3 then add_1 using rs1=r3 -> stall_d high for exactly 1 cycle; one bubble (control_signals_e=0); add_1 reaches EX on the next cycle.
- vldr v2 then AddRoundKey using vrs1=v2, VLOAD_STALL=2 -> two bubbles, then control_signals_e[4:0]=5'b10011 with vrs1_data_e equal to the held input.
- ldr r3 then add_1 using r4 -> no stall; back-to-back issue.
- flush_e asserted in the cycle an H_v stall begins -> stall_d=0, EX bubble, state RUN; the next fetched instruction enters EX one cycle later.
- AddRoundKey writing v1, followed by ShiftRows reading v1 -> no stall (not a load).

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared control-word fields, opcodes and stage FSM state
package cpu_pkg;

    localparam int CTRL_W = 20;

    // Control word bit positions
    localparam int CTRL_LOAD    = 18;
    localparam int CTRL_WRE     = 17;
    localparam int CTRL_VWRE    = 16;
    localparam int CTRL_WME_A   = 15;
    localparam int CTRL_WME_B   = 14;
    localparam int CTRL_WB_LO   = 12;
    localparam int CTRL_VWB_LO  = 10;
    localparam int CTRL_ALU_LO  = 5;
    localparam int CTRL_VOP_LO  = 0;
    localparam int OP_W         = 5;

    // Opcodes carried in aluOp / aluVectorOp
    localparam logic [OP_W-1:0] OP_ADD1       = 5'b00001;
    localparam logic [OP_W-1:0] OP_LDR        = 5'b00010;
    localparam logic [OP_W-1:0] OP_VLDR       = 5'b10010;
    localparam logic [OP_W-1:0] OP_ADDROUNDKEY = 5'b10011;
    localparam logic [OP_W-1:0] OP_SHIFTROWS  = 5'b10100;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/decode_execute_stage_if.sv
// rtl/decode_execute_stage_if.sv - decode-to-execute boundary bus
interface decode_execute_stage_if #(
    parameter int DATA_W      = 16,
    parameter int VDATA_W     = 128,
    parameter int REG_ADDR_W  = 4,
    parameter int VREG_ADDR_W = 3
);
    import cpu_pkg::*;

    logic                   valid_d;
    logic [CTRL_W-1:0]      control_signals_d;
    logic [REG_ADDR_W-1:0]  rd_d, rs1_d, rs2_d;
    logic                   use_rs1_d, use_rs2_d;
    logic [VREG_ADDR_W-1:0] vrd_d, vrs1_d, vrs2_d;
    logic                   use_vrs1_d, use_vrs2_d;
    logic [DATA_W-1:0]      rs1_data_d, rs2_data_d;
    logic [VDATA_W-1:0]     vrs1_data_d, vrs2_data_d;
    logic                   flush_e;

    logic                   stall_d;
    logic                   valid_e;
    logic [CTRL_W-1:0]      control_signals_e;
    logic [REG_ADDR_W-1:0]  rd_e;
    logic [VREG_ADDR_W-1:0] vrd_e;
    logic [DATA_W-1:0]      rs1_data_e, rs2_data_e;
    logic [VDATA_W-1:0]     vrs1_data_e, vrs2_data_e;

    // Pipeline stage side
    modport slave (
        input  valid_d, control_signals_d, rd_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d,
               vrd_d, vrs1_d, vrs2_d, use_vrs1_d, use_vrs2_d,
               rs1_data_d, rs2_data_d, vrs1_data_d, vrs2_data_d, flush_e,
        output stall_d, valid_e, control_signals_e, rd_e, vrd_e,
               rs1_data_e, rs2_data_e, vrs1_data_e, vrs2_data_e
    );

    // Decode / execute environment side
    modport master (
        output valid_d, control_signals_d, rd_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d,
               vrd_d, vrs1_d, vrs2_d, use_vrs1_d, use_vrs2_d,
               rs1_data_d, rs2_data_d, vrs1_data_d, vrs2_data_d, flush_e,
        input  stall_d, valid_e, control_signals_e, rd_e, vrd_e,
               rs1_data_e, rs2_data_e, vrs1_data_e, vrs2_data_e
    );

endinterface

// File: rtl/decode_execute_stage_hazard_detect.sv
// rtl/decode_execute_stage_hazard_detect.sv - load-use hazard detection against EX
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int VREG_ADDR_W = 3
) (
    input  logic                   valid_e,
    input  logic                   load_e,
    input  logic                   wre_e,
    input  logic                   vwre_e,
    input  logic [OP_W-1:0]        vop_e,
    input  logic [REG_ADDR_W-1:0]  rd_e,
    input  logic [VREG_ADDR_W-1:0] vrd_e,
    input  logic                   valid_d,
    input  logic [REG_ADDR_W-1:0]  rs1_d,
    input  logic [REG_ADDR_W-1:0]  rs2_d,
    input  logic                   use_rs1_d,
    input  logic                   use_rs2_d,
    input  logic [VREG_ADDR_W-1:0] vrs1_d,
    input  logic [VREG_ADDR_W-1:0] vrs2_d,
    input  logic                   use_vrs1_d,
    input  logic                   use_vrs2_d,
    output logic                   h_s,
    output logic                   h_v
);

    logic s_match;
    logic v_match;

    assign s_match = (use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e));
    assign v_match = (use_vrs1_d & (vrs1_d == vrd_e)) | (use_vrs2_d & (vrs2_d == vrd_e));

    // Only a vector load stalls; vector ALU results reach decode by forwarding
    assign h_s = valid_e & load_e & wre_e & valid_d & s_match;
    assign h_v = valid_e & vwre_e & (vop_e == OP_VLDR) & valid_d & v_match;

endmodule

// File: rtl/decode_execute_stage.sv
// rtl/decode_execute_stage.sv - D/EX pipeline registers with load-use stall FSM
module decode_execute_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int VDATA_W     = 128,
    parameter int REG_ADDR_W  = 4,
    parameter int VREG_ADDR_W = 3,
    parameter int VLOAD_STALL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_execute_stage_if.slave bus
);

    state_t       state, state_n;
    logic [2:0]   cnt, cnt_n;
    logic         h_s, h_v;
    logic         stall;
    logic         bubble;

    hazard_detect #(
        .REG_ADDR_W  (REG_ADDR_W),
        .VREG_ADDR_W (VREG_ADDR_W)
    ) u_hazard (
        .valid_e    (bus.valid_e),
        .load_e     (bus.control_signals_e[CTRL_LOAD]),
        .wre_e      (bus.control_signals_e[CTRL_WRE]),
        .vwre_e     (bus.control_signals_e[CTRL_VWRE]),
        .vop_e      (bus.control_signals_e[CTRL_VOP_LO +: OP_W]),
        .rd_e       (bus.rd_e),
        .vrd_e      (bus.vrd_e),
        .valid_d    (bus.valid_d),
        .rs1_d      (bus.rs1_d),
        .rs2_d      (bus.rs2_d),
        .use_rs1_d  (bus.use_rs1_d),
        .use_rs2_d  (bus.use_rs2_d),
        .vrs1_d     (bus.vrs1_d),
        .vrs2_d     (bus.vrs2_d),
        .use_vrs1_d (bus.use_vrs1_d),
        .use_vrs2_d (bus.use_vrs2_d),
        .h_s        (h_s),
        .h_v        (h_v)
    );

    // State register and bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: a vector load-use enters STALL for the remaining bubbles
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (bus.flush_e) begin
            state_n = RUN;
            cnt_n   = 3'd0;
        end else if (state == RUN) begin
            if (h_v && (VLOAD_STALL > 1)) begin
                state_n = STALL;
                cnt_n   = 3'(VLOAD_STALL - 1);
            end
        end else begin
            if (cnt == 3'd1) begin
                state_n = RUN;
                cnt_n   = 3'd0;
            end else begin
                cnt_n = cnt - 3'd1;
            end
        end
    end

    // Outputs: flush wins and releases decode so fetch can redirect
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        if (bus.flush_e) begin
            bubble = 1'b1;
        end else begin
            stall  = (state == STALL) | h_s | h_v;
            bubble = stall | ~bus.valid_d;
        end
        if (rst) begin
            stall = 1'b0;
        end
    end

    assign bus.stall_d = stall;

    // EX registers; a bubble clears valid/control and keeps operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_e           <= 1'b0;
            bus.control_signals_e <= '0;
            bus.rd_e              <= '0;
            bus.vrd_e             <= '0;
            bus.rs1_data_e        <= '0;
            bus.rs2_data_e        <= '0;
            bus.vrs1_data_e       <= '0;
            bus.vrs2_data_e       <= '0;
        end else if (bubble) begin
            bus.valid_e           <= 1'b0;
            bus.control_signals_e <= '0;
        end else begin
            bus.valid_e           <= 1'b1;
            bus.control_signals_e <= bus.control_signals_d;
            bus.rd_e              <= bus.rd_d;
            bus.vrd_e             <= bus.vrd_d;
            bus.rs1_data_e        <= bus.rs1_data_d;
            bus.rs2_data_e        <= bus.rs2_data_d;
            bus.vrs1_data_e       <= bus.vrs1_data_d;
            bus.vrs2_data_e       <= bus.vrs2_data_d;
        end
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// tb/tb_decode_execute_stage.sv - directed self-checking bench for decode_execute_stage
module tb_decode_execute_stage;

    localparam logic [19:0] C_LDR  = 20'h60040;
    localparam logic [19:0] C_ADD1 = 20'h20020;
    localparam logic [19:0] C_VLDR = 20'h10012;
    localparam logic [19:0] C_ARK  = 20'h10013;
    localparam logic [19:0] C_SHR  = 20'h10014;
    localparam logic [127:0] V_KEY = 128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D;
    localparam logic [127:0] V_ROW = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    decode_execute_stage_if #(
        .DATA_W(16), .VDATA_W(128), .REG_ADDR_W(4), .VREG_ADDR_W(3)
    ) bus ();

    decode_execute_stage #(
        .DATA_W(16), .VDATA_W(128), .REG_ADDR_W(4), .VREG_ADDR_W(3), .VLOAD_STALL(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        bus.valid_d = 1'b0;
        bus.control_signals_d = '0;
        bus.rd_d = '0; bus.rs1_d = '0; bus.rs2_d = '0;
        bus.use_rs1_d = 1'b0; bus.use_rs2_d = 1'b0;
        bus.vrd_d = '0; bus.vrs1_d = '0; bus.vrs2_d = '0;
        bus.use_vrs1_d = 1'b0; bus.use_vrs2_d = 1'b0;
        bus.rs1_data_d = '0; bus.rs2_data_d = '0;
        bus.vrs1_data_d = '0; bus.vrs2_data_d = '0;
        bus.flush_e = 1'b0;
    endtask

    task automatic scalar(input logic [19:0] c, input logic [3:0] rd, input logic [3:0] rs1,
                          input logic u1, input logic [15:0] d1);
        clear_d();
        bus.valid_d = 1'b1; bus.control_signals_d = c; bus.rd_d = rd;
        bus.rs1_d = rs1; bus.use_rs1_d = u1; bus.rs1_data_d = d1;
    endtask

    task automatic vector(input logic [19:0] c, input logic [2:0] vrd, input logic [2:0] vrs1,
                          input logic u1, input logic [127:0] d1);
        clear_d();
        bus.valid_d = 1'b1; bus.control_signals_d = c; bus.vrd_d = vrd;
        bus.vrs1_d = vrs1; bus.use_vrs1_d = u1; bus.vrs1_data_d = d1;
    endtask

    initial begin
        clear_d();
        #2;
        check("rst_valid_e", 128'(bus.valid_e), 128'd0);
        check("rst_ctrl_e", 128'(bus.control_signals_e), 128'd0);
        check("rst_stall", 128'(bus.stall_d), 128'd0);
        #1 rst = 1'b0;

        // ldr r3 then add_1 reading r3: one bubble
        scalar(C_LDR, 4'd3, 4'd0, 1'b0, 16'h0011);
        #1 check("ldr_nostall", 128'(bus.stall_d), 128'd0);
        tick();
        check("ldr_ctrl_e", 128'(bus.control_signals_e), 128'(C_LDR));
        check("ldr_rd_e", 128'(bus.rd_e), 128'd3);
        scalar(C_ADD1, 4'd5, 4'd3, 1'b1, 16'h1234);
        #1 check("hs_stall", 128'(bus.stall_d), 128'd1);
        tick();
        check("hs_bubble_valid", 128'(bus.valid_e), 128'd0);
        check("hs_bubble_ctrl", 128'(bus.control_signals_e), 128'd0);
        check("hs_bubble_hold_data", 128'(bus.rs1_data_e), 128'h0011);
        check("hs_stall_released", 128'(bus.stall_d), 128'd0);
        tick();
        check("hs_add_ctrl", 128'(bus.control_signals_e), 128'(C_ADD1));
        check("hs_add_data", 128'(bus.rs1_data_e), 128'h1234);

        // ldr r3 then add_1 reading r4: back-to-back
        scalar(C_LDR, 4'd3, 4'd0, 1'b0, 16'h0022);
        tick();
        scalar(C_ADD1, 4'd6, 4'd4, 1'b1, 16'h4444);
        #1 check("nohaz_stall", 128'(bus.stall_d), 128'd0);
        tick();
        check("nohaz_ctrl", 128'(bus.control_signals_e), 128'(C_ADD1));
        check("nohaz_valid", 128'(bus.valid_e), 128'd1);

        // vldr v2 then AddRoundKey reading v2: two bubbles
        vector(C_VLDR, 3'd2, 3'd0, 1'b0, '0);
        tick();
        vector(C_ARK, 3'd3, 3'd2, 1'b1, V_KEY);
        #1 check("hv_stall1", 128'(bus.stall_d), 128'd1);
        tick();
        check("hv_bubble1_ctrl", 128'(bus.control_signals_e), 128'd0);
        check("hv_stall2", 128'(bus.stall_d), 128'd1);
        tick();
        check("hv_bubble2_valid", 128'(bus.valid_e), 128'd0);
        check("hv_stall_released", 128'(bus.stall_d), 128'd0);
        tick();
        check("hv_ark_op", 128'(bus.control_signals_e[4:0]), 128'(5'b10011));
        check("hv_ark_data", bus.vrs1_data_e, V_KEY);

        // flush in the cycle an H_v stall begins
        vector(C_VLDR, 3'd2, 3'd0, 1'b0, '0);
        tick();
        vector(C_ARK, 3'd3, 3'd2, 1'b1, V_KEY);
        bus.flush_e = 1'b1;
        #1 check("flush_stall", 128'(bus.stall_d), 128'd0);
        tick();
        check("flush_bubble", 128'(bus.valid_e), 128'd0);
        scalar(C_ADD1, 4'd7, 4'd1, 1'b1, 16'h7777);
        #1 check("flush_run", 128'(bus.stall_d), 128'd0);
        tick();
        check("flush_next_ctrl", 128'(bus.control_signals_e), 128'(C_ADD1));
        check("flush_next_data", 128'(bus.rs1_data_e), 128'h7777);

        // AddRoundKey writes v1, ShiftRows reads v1: no stall
        vector(C_ARK, 3'd1, 3'd0, 1'b0, V_KEY);
        tick();
        vector(C_SHR, 3'd4, 3'd1, 1'b1, V_ROW);
        #1 check("valu_nostall", 128'(bus.stall_d), 128'd0);
        tick();
        check("valu_shr_ctrl", 128'(bus.control_signals_e), 128'(C_SHR));
        check("valu_shr_data", bus.vrs1_data_e, V_ROW);

        // idle decode slot
        clear_d();
        tick();
        check("idle_valid", 128'(bus.valid_e), 128'd0);
        check("idle_ctrl", 128'(bus.control_signals_e), 128'd0);

        // asynchronous reset while in STALL
        vector(C_VLDR, 3'd2, 3'd0, 1'b0, V_ROW);
        tick();
        vector(C_ARK, 3'd3, 3'd2, 1'b1, V_KEY);
        tick();
        check("mid_stall_active", 128'(bus.stall_d), 128'd1);
        rst = 1'b1;
        #1;
        check("arst_stall", 128'(bus.stall_d), 128'd0);
        check("arst_vrs1_data", bus.vrs1_data_e, 128'd0);
        check("arst_rd_vrd", 128'({bus.rd_e, bus.vrd_e}), 128'd0);
        check("arst_valid", 128'(bus.valid_e), 128'd0);
        #1 rst = 1'b0;
        #1 check("arst_run_nostall", 128'(bus.stall_d), 128'd0);
        tick();
        check("arst_ark_ctrl", 128'(bus.control_signals_e), 128'(C_ARK));
        check("arst_ark_data", bus.vrs1_data_e, V_KEY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
